// File: rtl/playfield_mem_if.sv
// Playfield storage bus: write port, GPU read port and line-clear handshake.
interface playfield_mem_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = 3
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS + 1);

    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [CW-1:0] wr_color;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [CW-1:0] rd_color;
    logic          rd_occ;
    logic [ROWS-1:0] row_full;
    logic          clear_start;
    logic          busy;
    logic          clear_done;
    logic [LW-1:0] lines_cleared;

    // Game logic / GPU side
    modport master (
        output wr_en, wr_x, wr_y, wr_color, rd_x, rd_y, clear_start,
        input  rd_color, rd_occ, row_full, busy, clear_done, lines_cleared
    );

    // Playfield memory side
    modport slave (
        input  wr_en, wr_x, wr_y, wr_color, rd_x, rd_y, clear_start,
        output rd_color, rd_occ, row_full, busy, clear_done, lines_cleared
    );
endinterface

// File: rtl/playfield_mem.sv
// Tetris playfield storage with random-access write, registered read and a
// bottom-up line-clear sequencer that collapses one full row per cycle.
module playfield_mem #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    playfield_mem_if.slave  bus
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS + 1);

    localparam logic [XW-1:0] COL_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] ROW_MAX = YW'(ROWS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [COLS-1:0][CW-1:0] board_q [ROWS];
    logic [1:0]      state_q, state_d;
    logic [YW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   lines_q, lines_d;
    logic [CW-1:0]   rd_color_q, rd_color_d;
    logic            rd_occ_q;
    logic [ROWS-1:0] row_full_s;
    logic            wr_ok_s;
    logic            shift_s;

    assign wr_ok_s = (state_q == ST_IDLE) && bus.wr_en &&
                     (bus.wr_x <= COL_MAX) && (bus.wr_y <= ROW_MAX);
    // A full row under the pointer collapses the board this cycle
    assign shift_s = (state_q == ST_SCAN) && row_full_s[ptr_q];

    // Row-full flags: a row is full when no cell holds the empty colour
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_full_s[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                row_full_s[r] = row_full_s[r] & (|board_q[r][c]);
            end
        end
    end

    // Read mux: out-of-range coordinates read as empty
    always_comb begin
        rd_color_d = {CW{1'b0}};
        if ((bus.rd_x <= COL_MAX) && (bus.rd_y <= ROW_MAX)) begin
            rd_color_d = board_q[bus.rd_y][bus.rd_x];
        end else begin
            rd_color_d = {CW{1'b0}};
        end
    end

    // Line-clear sequencer next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lines_d = lines_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d = ST_SCAN;
                    ptr_d   = ROW_MAX;
                    lines_d = {LW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (row_full_s[ptr_q]) begin
                    // Pointer held: the row that dropped in is re-checked
                    lines_d = lines_q + LW'(1);
                end else if (ptr_q == {YW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q - YW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = ROW_MAX;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= ROW_MAX;
            lines_q <= {LW{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lines_q <= lines_d;
        end
    end

    // Board storage: idle-time writes and single-cycle row collapse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                board_q[r] <= '0;
            end
        end else if (shift_s) begin
            for (int k = ROWS - 1; k >= 1; k--) begin
                if (YW'(k) <= ptr_q) begin
                    board_q[k] <= board_q[k-1];
                end
            end
            board_q[0] <= '0;
        end else if (wr_ok_s) begin
            board_q[bus.wr_y][bus.wr_x] <= bus.wr_color;
        end
    end

    // Registered GPU read port, sampled before any same-edge write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_color_q <= {CW{1'b0}};
            rd_occ_q   <= 1'b0;
        end else begin
            rd_color_q <= rd_color_d;
            rd_occ_q   <= |rd_color_d;
        end
    end

    assign bus.rd_color      = rd_color_q;
    assign bus.rd_occ        = rd_occ_q;
    assign bus.row_full      = row_full_s;
    assign bus.busy          = (state_q == ST_SCAN);
    assign bus.clear_done    = (state_q == ST_DONE);
    assign bus.lines_cleared = lines_q;
endmodule

// File: tb/tb_playfield_mem.sv
// Randomised self-checking bench for playfield_mem against a row-compaction model.
module tb_playfield_mem;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CW   = 3;

    logic clk;
    logic reset;

    playfield_mem_if #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) pf ();

    playfield_mem #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;
    int mb [ROWS][COLS];

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_full(input int r);
        for (int c = 0; c < COLS; c++) begin
            if (mb[r][c] == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Remove every full row and let the remaining rows fall to the bottom
    function automatic int model_clear();
        int nb [ROWS][COLS];
        int dst = ROWS - 1;
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) nb[r][c] = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (model_full(r)) begin
                n++;
            end else begin
                for (int c = 0; c < COLS; c++) nb[dst][c] = mb[r][c];
                dst--;
            end
        end
        mb = nb;
        return n;
    endfunction

    function automatic void model_zero();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    endfunction

    task automatic do_write(input int x, input int y, input int col);
        pf.wr_en    = 1'b1;
        pf.wr_x     = 4'(x);
        pf.wr_y     = 5'(y);
        pf.wr_color = 3'(col);
        tick();
        pf.wr_en = 1'b0;
        if (x < COLS && y < ROWS) mb[y][x] = col;
    endtask

    task automatic read_check(input int x, input int y);
        int exp;
        pf.rd_x = 4'(x);
        pf.rd_y = 5'(y);
        tick();
        exp = (x < COLS && y < ROWS) ? mb[y][x] : 0;
        check($sformatf("rd_color(%0d,%0d)", x, y), int'(pf.rd_color), exp);
        check($sformatf("rd_occ(%0d,%0d)", x, y), int'(pf.rd_occ), int'(exp != 0));
    endtask

    task automatic check_board(input string tag);
        int exp_full = 0;
        for (int r = 0; r < ROWS; r++) if (model_full(r)) exp_full |= (1 << r);
        check({tag, " row_full"}, int'(pf.row_full), exp_full);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) read_check(x, y);
    endtask

    // One clear pass; optional same-cycle write, optional ignored stimulus mid-pass
    task automatic run_pass(input string tag, input bit inject, input bit co_write,
                            input int cx, input int cy, input int cc);
        int n;
        int cnt = 0;
        pf.clear_start = 1'b1;
        if (co_write) begin
            pf.wr_en = 1'b1;
            pf.wr_x = 4'(cx);
            pf.wr_y = 5'(cy);
            pf.wr_color = 3'(cc);
            mb[cy][cx] = cc;
        end
        n = model_clear();
        tick();
        pf.clear_start = 1'b0;
        pf.wr_en = 1'b0;
        while (pf.busy && cnt < 100) begin
            cnt++;
            if (inject && cnt == 2) begin
                pf.wr_en = 1'b1;
                pf.wr_x = 4'd4;
                pf.wr_y = 5'd10;
                pf.wr_color = 3'd7;
                pf.clear_start = 1'b1;
            end else begin
                pf.wr_en = 1'b0;
                pf.clear_start = 1'b0;
            end
            tick();
        end
        pf.wr_en = 1'b0;
        pf.clear_start = 1'b0;
        check({tag, " busy_cycles"}, cnt, ROWS + n);
        check({tag, " clear_done"}, int'(pf.clear_done), 1);
        check({tag, " busy_in_done"}, int'(pf.busy), 0);
        check({tag, " lines_cleared"}, int'(pf.lines_cleared), n);
        if (inject) pf.clear_start = 1'b1;
        tick();
        pf.clear_start = 1'b0;
        check({tag, " done_pulse_end"}, int'(pf.clear_done), 0);
        check({tag, " busy_after"}, int'(pf.busy), 0);
        check({tag, " lines_hold"}, int'(pf.lines_cleared), n);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_zero();
        tick();
    endtask

    initial begin
        int done_seen;
        reset = 1'b0;
        pf.wr_en = 1'b0; pf.wr_x = '0; pf.wr_y = '0; pf.wr_color = '0;
        pf.rd_x = '0; pf.rd_y = '0; pf.clear_start = 1'b0;
        model_zero();
        repeat (3) tick();
        check("rst rd_color", int'(pf.rd_color), 0);
        check("rst rd_occ", int'(pf.rd_occ), 0);
        check("rst busy", int'(pf.busy), 0);
        check("rst clear_done", int'(pf.clear_done), 0);
        check("rst lines", int'(pf.lines_cleared), 0);
        reset = 1'b1;
        tick();

        // Basic write/read and out-of-range handling
        do_write(3, 7, 5);
        read_check(3, 7);
        read_check(4, 7);
        do_write(COLS, 7, 6);
        do_write(2, ROWS, 6);
        read_check(COLS, 7);
        read_check(3, 25);
        check_board("wr");

        // Mid-run reset clears everything
        for (int x = 0; x < COLS; x++) do_write(x, 19, 1);
        run_pass("pre", 1'b0, 1'b0, 0, 0, 0);
        pulse_reset();
        check("rst2 lines", int'(pf.lines_cleared), 0);
        check_board("rst2");

        // Single clear
        for (int x = 0; x < COLS; x++) do_write(x, 19, 2);
        do_write(0, 18, 6);
        run_pass("single", 1'b0, 1'b0, 0, 0, 0);
        check_board("single");

        // Non-adjacent and stacked
        pulse_reset();
        for (int x = 0; x < COLS; x++) begin
            do_write(x, 19, 1 + x % 7);
            do_write(x, 18, 3);
            do_write(x, 15, 4);
        end
        do_write(1, 14, 7);
        run_pass("stack", 1'b0, 1'b0, 0, 0, 0);
        check("stack marker", mb[17][1], 7);
        check_board("stack");

        // Top row, with ignored write / clear_start mid-pass and in DONE
        pulse_reset();
        for (int x = 0; x < COLS; x++) do_write(x, 0, 5);
        run_pass("top", 1'b1, 1'b0, 0, 0, 0);
        check_board("top");

        // Write completes a row in the same cycle the pass starts
        pulse_reset();
        for (int x = 0; x < COLS - 1; x++) do_write(x, 19, 3);
        do_write(2, 17, 1);
        run_pass("cowr", 1'b0, 1'b1, COLS - 1, 19, 4);
        check_board("cowr");

        // Mid-pass reset
        pulse_reset();
        for (int x = 0; x < COLS; x++) begin
            do_write(x, 19, 2);
            do_write(x, 18, 6);
        end
        pf.clear_start = 1'b1;
        tick();
        pf.clear_start = 1'b0;
        tick();
        check("mid busy_before", int'(pf.busy), 1);
        reset = 1'b0;
        #1;
        check("mid busy_in_rst", int'(pf.busy), 0);
        model_zero();
        done_seen = 0;
        repeat (3) begin
            tick();
            if (pf.clear_done) done_seen++;
        end
        reset = 1'b1;
        repeat (25) begin
            tick();
            if (pf.clear_done) done_seen++;
        end
        check("mid no_done", done_seen, 0);
        check("mid busy_idle", int'(pf.busy), 0);
        check_board("mid");

        // Randomised rounds
        for (int round = 0; round < 6; round++) begin
            for (int y = 8; y < ROWS; y++) begin
                int kind = int'($urandom_range(0, 3));
                if (kind == 0) begin
                    for (int x = 0; x < COLS; x++) do_write(x, y, int'($urandom_range(1, 7)));
                end else if (kind == 1) begin
                    for (int x = 0; x < COLS; x++) do_write(x, y, int'($urandom_range(0, 7)));
                    do_write(int'($urandom_range(0, COLS - 1)), y, 0);
                end
            end
            do_write(int'($urandom_range(COLS, 15)), int'($urandom_range(0, 31)), 7);
            do_write(int'($urandom_range(0, 15)), int'($urandom_range(ROWS, 31)), 7);
            run_pass($sformatf("rnd%0d", round), round[0], 1'b0, 0, 0, 0);
            check_board($sformatf("rnd%0d", round));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
